// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over a req/ack port and sequences the next PC
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        branch,
   input  logic        bmem,
   input  logic        jmem,
   input  logic        eq,
   input  logic [31:0] mem_target,
   input  logic        stall,
   output logic        misalign
);
   typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
   state_t      state_q;
   logic [31:0] pc_q, instr_q, pc_d, br_target;
   logic        misalign_q, mem_taken;
   assign pc_plus4    = pc_q + 32'd4;
   assign mem_taken   = jmem | (bmem & eq);
   assign br_target   = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign pc_d        = mem_taken ? mem_target : (branch & eq) ? br_target : pc_plus4;
   assign imem_req    = state_q == FETCH;
   assign instr_valid = state_q == EXEC;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign misalign    = misalign_q;
   // sequencer: boot, fetch until ack, execute until unstalled, halt on a misaligned memory target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         case (state_q)
            BOOT: state_q <= FETCH;
            FETCH: if (imem_ack) begin
               instr_q <= imem_rdata;
               state_q <= EXEC;
            end
            EXEC: if (!stall) begin
               if (mem_taken && mem_target[1:0] != 2'b00) begin
                  misalign_q <= 1'b1;
                  state_q    <= HALT;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= FETCH;
               end
            end
            default: state_q <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized transaction-level check of fetch_sequencer against a next-PC model
module tb_fetch_sequencer;
   logic        clk = 1'b0, rst_n;
   logic        imem_req, imem_ack = 1'b0, instr_valid, misalign;
   logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4, mem_target = '0;
   logic [5:0]  opcode, funct;
   logic        branch = 1'b0, bmem = 1'b0, jmem = 1'b0, eq = 1'b0, stall = 1'b0;
   int          errs = 0, checks = 0;
   logic [31:0] mpc;
   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .funct(funct), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
      .branch(branch), .bmem(bmem), .jmem(jmem), .eq(eq), .mem_target(mem_target),
      .stall(stall), .misalign(misalign)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst_n = 1'b0;
      #2;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc4", pc_plus4, 32'h4);
      chk("rst_mis", misalign, 0);
      chk("rst_opf", {opcode, funct}, 0);
      step;
      step;
      rst_n = 1'b1;
      chk("boot_req", imem_req, 0);
      mpc = 32'h0;
      step;
   endtask
   // one full instruction: W wait cycles, S stall cycles, then the given decoder strobes
   task automatic run_instr(input int w, input int s, input logic [31:0] word,
                            input logic br, input logic bm, input logic jm, input logic e,
                            input logic [31:0] mt);
      logic [31:0] nxt;
      chk("req", imem_req, 1);
      chk("addr", imem_addr, mpc);
      chk("valid_f", instr_valid, 0);
      repeat (w) begin
         imem_ack = 1'b0;
         imem_rdata = $urandom;
         step;
         chk("req_hold", imem_req, 1);
         chk("addr_hold", imem_addr, mpc);
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      step;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      chk("valid", instr_valid, 1);
      chk("req_e", imem_req, 0);
      chk("instr", instr, word);
      chk("pc", pc, mpc);
      chk("pc4", pc_plus4, mpc + 32'd4);
      chk("opcode", opcode, word[31:26]);
      chk("funct", funct, word[5:0]);
      repeat (s) begin
         stall = 1'b1;
         {branch, bmem, jmem, eq} = 4'($urandom);
         mem_target = $urandom;
         step;
         chk("valid_s", instr_valid, 1);
         chk("pc_s", pc, mpc);
         chk("instr_s", instr, word);
      end
      stall = 1'b0;
      {branch, bmem, jmem, eq} = {br, bm, jm, e};
      mem_target = mt;
      step;
      imem_ack = 1'b0;
      {branch, bmem, jmem, eq} = 4'b0;
      if (jm || (bm && e)) nxt = mt;
      else if (br && e) nxt = mpc + 32'd4 + 32'(4 * int'($signed(word[15:0])));
      else nxt = mpc + 32'd4;
      if ((jm || (bm && e)) && (mt % 4 != 0)) begin
         chk("mis_set", misalign, 1);
         chk("mis_req", imem_req, 0);
         chk("mis_valid", instr_valid, 0);
         chk("mis_pc", pc, mpc);
         repeat (3) begin
            imem_ack = 1'b1;
            step;
            chk("halt_req", imem_req, 0);
            chk("halt_mis", misalign, 1);
            chk("halt_pc", pc, mpc);
         end
         imem_ack = 1'b0;
         do_reset;
      end else begin
         chk("mis_clr", misalign, 0);
         mpc = nxt;
      end
   endtask
   initial begin
      rst_n = 1'b1;
      #1;
      do_reset;
      repeat (4) run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      run_instr(3, 2, 32'h0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 32'h0, 0, 0, 1, 0, 32'h100);
      run_instr(0, 0, 32'h1000_FFFF, 1, 0, 0, 1, 0);
      run_instr(0, 0, 32'h1000_0004, 1, 0, 0, 1, 0);
      run_instr(0, 0, 32'h0, 0, 0, 1, 0, 32'h100);
      run_instr(0, 0, 32'h1000_0004, 1, 0, 0, 0, 0);
      run_instr(0, 0, 32'h0, 0, 0, 1, 0, 32'h100);
      run_instr(1, 0, 32'h1000_0004, 1, 0, 1, 1, 32'h2000);
      run_instr(0, 0, 32'h0, 0, 0, 1, 0, 32'h100);
      run_instr(0, 1, 32'h0, 0, 1, 0, 0, 32'h3000);
      run_instr(0, 0, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFC);
      run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      run_instr(0, 0, 32'h0, 0, 0, 1, 1, 32'h2002);
      run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
         logic [31:0] mt;
         logic [3:0]  sb;
         mt = $urandom;
         if ($urandom_range(0, 4) != 0) mt[1:0] = 2'b00;
         sb = 4'($urandom);
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   sb[0], sb[1], sb[2] & sb[3], 1'($urandom_range(0, 1)), mt);
      end
      imem_ack = 1'b0;
      step;
      chk("midf_req", imem_req, 1);
      do_reset;
      run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      imem_ack = 1'b1;
      step;
      imem_ack = 1'b0;
      chk("mide_valid", instr_valid, 1);
      do_reset;
      run_instr(0, 0, 32'h0, 0, 0, 0, 0, 0);
      chk("final_addr", imem_addr, mpc);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
